// File: rtl/statistic_stim_gen.sv
// statistic_stim_gen
//   Stimulus source for the statistic counter block. On start it issues one
//   clear cycle and then streams num_pairs byte pairs on DataOut1/DataOut2
//   from the selected pattern mode. A done pulse follows the last pair.
//   The block also keeps a registered model of the counter's EvenParity,
//   GreyCode and overflow outputs. This model is cycle-aligned with the
//   counter, so the outputs can be compared directly.
// Ports
//   clock, reset           rising-edge clock, async active-high reset
//   start, abort           begin a burst (IDLE only) / end RUN early (RUN only)
//   mode[1:0]              0 LFSR, 1 grey alternating, 2 even-parity LFSR, 3 idle words
//   num_pairs[7:0]         pairs per burst, 0..255
//   seed[7:0]              lane-1 LFSR seed; lane 2 uses ~seed
//   DataOut1/2[7:0]        registered lane data toward the counter
//   clear_out              registered counter clear
//   pair_valid, busy, done burst status
//   exp_even, exp_grey     counter output model
//   exp_ovf                sticky overflow model
module statistic_stim_gen #(
  parameter logic [7:0] IDLE_WORD = 8'h01,
  parameter logic [7:0] ZERO_SUB  = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] mode,
  input  logic [7:0] num_pairs,
  input  logic [7:0] seed,
  output logic [7:0] DataOut1,
  output logic [7:0] DataOut2,
  output logic       clear_out,
  output logic       pair_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] exp_even,
  output logic [7:0] exp_grey,
  output logic       exp_ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // A zero seed would lock the LFSR at zero.
  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? ZERO_SUB : s;
  endfunction

  function automatic logic [7:0] force_even(input logic [7:0] l);
    return {l[7:1], ^l[7:1]};
  endfunction

  function automatic logic even_bit(input logic [7:0] v);
    return ~^v;
  endfunction

  function automatic logic grey_bit(input logic [7:0] v);
    return (v == 8'hAA) || (v == 8'h55);
  endfunction

  logic [1:0] state;
  logic [1:0] next_state;
  logic [1:0] mode_q;
  logic [7:0] cnt;
  logic [7:0] lfsr1;
  logic [7:0] lfsr2;
  logic       alt;
  logic [7:0] pat1;
  logic [7:0] pat2;
  logic [8:0] sum_even;
  logic [8:0] sum_grey;

  // Next-state decode; cnt holds the pairs still to send after the current one.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_CLEAR;
        else       next_state = S_IDLE;
      end
      S_CLEAR: begin
        if (cnt != 8'd0) next_state = S_RUN;
        else             next_state = S_DONE;
      end
      S_RUN: begin
        if (abort || (cnt == 8'd0)) next_state = S_DONE;
        else                        next_state = S_RUN;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Pattern generation from the current generator state.
  always_comb begin
    pat1 = IDLE_WORD;
    pat2 = IDLE_WORD;
    case (mode_q)
      2'd0: begin
        pat1 = lfsr1;
        pat2 = lfsr2;
      end
      2'd1: begin
        pat1 = alt ? 8'h55 : 8'hAA;
        pat2 = alt ? 8'hAA : 8'h55;
      end
      2'd2: begin
        pat1 = force_even(lfsr1);
        pat2 = force_even(lfsr2);
      end
      2'd3: begin
        pat1 = IDLE_WORD;
        pat2 = IDLE_WORD;
      end
      default: begin
        pat1 = IDLE_WORD;
        pat2 = IDLE_WORD;
      end
    endcase
  end

  // 9-bit model sums; bit 8 is the counter carry.
  always_comb begin
    sum_even = {1'b0, exp_even} + {8'd0, even_bit(DataOut1)} + {8'd0, even_bit(DataOut2)};
    sum_grey = {1'b0, exp_grey} + {8'd0, grey_bit(DataOut1)} + {8'd0, grey_bit(DataOut2)};
  end

  // FSM and registered outputs; outputs reflect the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      DataOut1   <= IDLE_WORD;
      DataOut2   <= IDLE_WORD;
      clear_out  <= 1'b0;
      pair_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= next_state;
      clear_out  <= (next_state == S_CLEAR);
      pair_valid <= (next_state == S_RUN);
      busy       <= (next_state != S_IDLE);
      done       <= (next_state == S_DONE);
      if (next_state == S_RUN) begin
        DataOut1 <= pat1;
        DataOut2 <= pat2;
      end else begin
        DataOut1 <= IDLE_WORD;
        DataOut2 <= IDLE_WORD;
      end
    end
  end

  // Burst parameters and pattern generators: load on start, step per emitted pair.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q <= 2'd0;
      cnt    <= 8'd0;
      lfsr1  <= ZERO_SUB;
      lfsr2  <= ZERO_SUB;
      alt    <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      mode_q <= mode;
      cnt    <= num_pairs;
      lfsr1  <= seed_fix(seed);
      lfsr2  <= seed_fix(~seed);
      alt    <= 1'b0;
    end else if (next_state == S_RUN) begin
      cnt    <= cnt - 8'd1;
      lfsr1  <= lfsr_step(lfsr1);
      lfsr2  <= lfsr_step(lfsr2);
      alt    <= ~alt;
    end else begin
      mode_q <= mode_q;
      cnt    <= cnt;
      lfsr1  <= lfsr1;
      lfsr2  <= lfsr2;
      alt    <= alt;
    end
  end

  // Counter model: clears with clear_out, otherwise accumulates the lanes on every edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_even <= 8'd0;
      exp_grey <= 8'd0;
      exp_ovf  <= 1'b0;
    end else if (clear_out) begin
      exp_even <= 8'd0;
      exp_grey <= 8'd0;
      exp_ovf  <= 1'b0;
    end else begin
      exp_even <= sum_even[7:0];
      exp_grey <= sum_grey[7:0];
      exp_ovf  <= exp_ovf | sum_even[8] | sum_grey[8];
    end
  end

endmodule

// File: tb/tb_statistic_stim_gen.sv
module tb_statistic_stim_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] num_pairs = 8'd0;
  logic [7:0] seed = 8'd0;
  logic [7:0] DataOut1, DataOut2, exp_even, exp_grey;
  logic       clear_out, pair_valid, busy, done, exp_ovf;

  int total = 0;
  int bad = 0;
  int pv_count = 0;
  int busy_count = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] fin_even, fin_grey;
  logic       fin_ovf;

  statistic_stim_gen dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .num_pairs(num_pairs), .seed(seed), .DataOut1(DataOut1), .DataOut2(DataOut2),
    .clear_out(clear_out), .pair_valid(pair_valid), .busy(busy), .done(done),
    .exp_even(exp_even), .exp_grey(exp_grey), .exp_ovf(exp_ovf)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] m_lfsr(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] m_fix(input logic [7:0] s);
    return (s == 8'h00) ? 8'hA5 : s;
  endfunction

  // Reference model: push the expected pairs and compute the final counter values.
  task automatic push_pairs(input logic [1:0] m, input int n, input logic [7:0] s);
    logic [7:0] l1, l2, a, b;
    logic [8:0] se, sg;
    l1 = m_fix(s);
    l2 = m_fix(~s);
    fin_even = 8'd0; fin_grey = 8'd0; fin_ovf = 1'b0;
    for (int k = 0; k < n; k++) begin
      case (m)
        2'd0: begin a = l1; b = l2; end
        2'd1: begin a = (k % 2 == 0) ? 8'hAA : 8'h55; b = (k % 2 == 0) ? 8'h55 : 8'hAA; end
        2'd2: begin a = {l1[7:1], ^l1[7:1]}; b = {l2[7:1], ^l2[7:1]}; end
        default: begin a = 8'h01; b = 8'h01; end
      endcase
      q1.push_back(a);
      q2.push_back(b);
      se = {1'b0, fin_even} + 9'(~^a) + 9'(~^b);
      sg = {1'b0, fin_grey} + 9'((a == 8'hAA) || (a == 8'h55)) + 9'((b == 8'hAA) || (b == 8'h55));
      fin_even = se[7:0];
      fin_grey = sg[7:0];
      fin_ovf = fin_ovf | se[8] | sg[8];
      l1 = m_lfsr(l1);
      l2 = m_lfsr(l2);
    end
  endtask

  // Pulse start for one edge; returns at the CLEAR-cycle negedge.
  task automatic start_burst(input logic [1:0] m, input logic [7:0] n, input logic [7:0] s);
    @(negedge clock);
    pv_count = 0;
    busy_count = 0;
    mode = m; num_pairs = n; seed = s; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Wait for done with a bound; last_pv is pair_valid in the cycle before done.
  task automatic wait_done(output bit ok, output logic last_pv);
    ok = 1'b0;
    last_pv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (done) begin
        ok = 1'b1;
        break;
      end
      last_pv = pair_valid;
    end
  endtask

  // Scoreboard monitor: every pair_valid cycle must match the next expected pair.
  always @(negedge clock) begin
    if (!reset) begin
      if (busy) busy_count++;
      if (pair_valid) begin
        pv_count++;
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL pair_unexpected got=%h/%h required=none", DataOut1, DataOut2);
        end else begin
          logic [7:0] e1, e2;
          e1 = q1.pop_front();
          e2 = q2.pop_front();
          if ({DataOut1, DataOut2} !== {e1, e2}) begin
            bad++;
            $display("FAIL pair got=%h/%h required=%h/%h", DataOut1, DataOut2, e1, e2);
          end
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clock);
    total++;
    if ({DataOut1, DataOut2, clear_out, pair_valid, busy, done, exp_even, exp_grey, exp_ovf} !==
        {8'h01, 8'h01, 4'b0000, 8'h00, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got=%h/%h c%b v%b b%b d%b e%h g%h o%b required=01/01 all zero",
               DataOut1, DataOut2, clear_out, pair_valid, busy, done, exp_even, exp_grey, exp_ovf);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    push_pairs(2'd0, 50, 8'h3C);
    start_burst(2'd0, 8'd50, 8'h3C);
    repeat (5) @(negedge clock);
    total++;
    if (pair_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrun_active got=%b required=1", pair_valid);
    end
    reset = 1'b1;
    #1;
    q1.delete();
    q2.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++;
    if ({DataOut1, DataOut2, busy, clear_out, pair_valid, exp_even, exp_grey, exp_ovf} !==
        {8'h01, 8'h01, 3'b000, 8'h00, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL midrun_reset got=%h/%h b%b c%b v%b e%h g%h o%b required=01/01 zeros",
               DataOut1, DataOut2, busy, clear_out, pair_valid, exp_even, exp_grey, exp_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL midrun_no_done got=d%b b%b required=d0 b0", done, busy);
      end
    end
  endtask

  task automatic test_grey3();
    bit ok;
    logic lp;
    push_pairs(2'd1, 3, 8'h00);
    start_burst(2'd1, 8'd3, 8'h00);
    total++;
    if (clear_out !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL grey3_clear got=c%b b%b required=c1 b1", clear_out, busy);
    end
    wait_done(ok, lp);
    total++;
    if (!ok || lp !== 1'b1) begin
      bad++;
      $display("FAIL grey3_done got=seen%b prevpv%b required=1/1", ok, lp);
    end
    total++;
    if ({exp_grey, exp_even, exp_ovf} !== {8'd6, 8'd6, 1'b0}) begin
      bad++;
      $display("FAIL grey3_model got=g%0d e%0d o%b required=g6 e6 o0", exp_grey, exp_even, exp_ovf);
    end
    @(negedge clock);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || pv_count != 3 || q1.size() != 0) begin
      bad++;
      $display("FAIL grey3_end got=d%b b%b pairs%0d left%0d required=d0 b0 pairs3 left0",
               done, busy, pv_count, q1.size());
    end
  endtask

  task automatic test_wrap128();
    bit ok;
    logic lp;
    push_pairs(2'd1, 128, 8'h00);
    start_burst(2'd1, 8'd128, 8'h00);
    wait_done(ok, lp);
    total++;
    if (!ok || {exp_grey, exp_even, exp_ovf} !== {8'd0, 8'd0, 1'b1}) begin
      bad++;
      $display("FAIL wrap128 got=seen%b g%0d e%0d o%b required=1 g0 e0 o1", ok, exp_grey, exp_even, exp_ovf);
    end
    repeat (3) @(negedge clock);
    total++;
    if (exp_ovf !== 1'b1 || pv_count != 128) begin
      bad++;
      $display("FAIL wrap128_sticky got=o%b pairs%0d required=o1 pairs128", exp_ovf, pv_count);
    end
  endtask

  task automatic test_idle_mode();
    bit ok;
    logic lp;
    push_pairs(2'd3, 10, 8'h77);
    start_burst(2'd3, 8'd10, 8'h77);
    total++;
    if (exp_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_until_clear got=%b required=1", exp_ovf);
    end
    wait_done(ok, lp);
    total++;
    if (!ok || {exp_even, exp_grey, exp_ovf} !== {8'd0, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL idle_model got=seen%b e%0d g%0d o%b required=1 e0 g0 o0", ok, exp_even, exp_grey, exp_ovf);
    end
    @(negedge clock);
    total++;
    if (pv_count != 10 || busy_count != 12) begin
      bad++;
      $display("FAIL idle_counts got=pairs%0d busy%0d required=pairs10 busy12", pv_count, busy_count);
    end
  endtask

  task automatic test_zero_pairs();
    start_burst(2'd1, 8'd0, 8'h12);
    total++;
    if (clear_out !== 1'b1) begin
      bad++;
      $display("FAIL zero_clear got=%b required=1", clear_out);
    end
    num_pairs = 8'd5;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    total++;
    if (done !== 1'b1 || clear_out !== 1'b0 || pair_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_done got=d%b c%b v%b required=d1 c0 v0", done, clear_out, pair_valid);
    end
    repeat (3) @(negedge clock);
    total++;
    if (busy !== 1'b0 || pv_count != 0 || busy_count != 2) begin
      bad++;
      $display("FAIL zero_ignore_start got=b%b pairs%0d busy%0d required=b0 pairs0 busy2",
               busy, pv_count, busy_count);
    end
  endtask

  task automatic test_abort_mode2();
    bit seen;
    int runs;
    push_pairs(2'd2, 5, 8'h00);
    start_burst(2'd2, 8'd20, 8'h00);
    seen = 1'b0;
    runs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      abort = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (pair_valid) begin
        runs++;
        total++;
        if ((^DataOut1) !== 1'b0 || (^DataOut2) !== 1'b0) begin
          bad++;
          $display("FAIL abort_parity got=%h/%h required=even parity", DataOut1, DataOut2);
        end
        if (runs == 5) abort = 1'b1;
      end
    end
    total++;
    if (!seen || runs != 5 || q1.size() != 0) begin
      bad++;
      $display("FAIL abort_count got=seen%b pairs%0d left%0d required=1 pairs5 left0", seen, runs, q1.size());
    end
    total++;
    if ({exp_even, exp_grey, exp_ovf} !== {8'd10, fin_grey, fin_ovf}) begin
      bad++;
      $display("FAIL abort_model got=e%0d g%0d o%b required=e10 g%0d o%b",
               exp_even, exp_grey, exp_ovf, fin_grey, fin_ovf);
    end
  endtask

  task automatic test_random_mode0();
    bit ok;
    logic lp;
    logic [7:0] s;
    for (int r = 0; r < 3; r++) begin
      s = (r == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      push_pairs(2'd0, 30, s);
      start_burst(2'd0, 8'd30, s);
      wait_done(ok, lp);
      total++;
      if (!ok || {exp_even, exp_grey, exp_ovf} !== {fin_even, fin_grey, fin_ovf}) begin
        bad++;
        $display("FAIL rand_model seed=%h got=seen%b e%0d g%0d o%b required=e%0d g%0d o%b",
                 s, ok, exp_even, exp_grey, exp_ovf, fin_even, fin_grey, fin_ovf);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_grey3();
    test_wrap128();
    test_idle_mode();
    test_zero_pairs();
    test_abort_mode2();
    test_random_mode0();
    total++;
    if (q1.size() != 0) begin
      bad++;
      $display("FAIL leftover_pairs got=%0d required=0", q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
